// File: rtl/issue_station.sv
// issue_station: renaming issue station with a tagged register file, CDB wakeup and in-order-by-index dispatch.
// Optional macro ISSUE_BYPASS_EN: an issue may capture a same-cycle CDB result instead of stalling.
`ifndef REG_SIZE
`define REG_SIZE 4
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef UNIT_SIZE
`define UNIT_SIZE 8
`endif

module issue_station #(
    parameter int                    ENTRIES   = 4,
    parameter logic [`UNIT_SIZE-1:0] READY_TAG = 8'h7F
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   unit,
    input  logic [`REG_SIZE-1:0]         reg1,
    input  logic [`REG_SIZE-1:0]         reg2,
    input  logic [`REG_SIZE-1:0]         reg3,
    input  logic                         hasimm,
    input  logic signed [`WORD_SIZE-1:0] imm,
    input  logic                         enable,
    output logic                         out,
    input  logic                         regread,
    input  logic [`REG_SIZE-1:0]         regin,
    output logic [`UNIT_SIZE-1:0]        regout,
    output logic signed [`WORD_SIZE-1:0] regoutrf,
    output logic                         dispatch_valid,
    input  logic                         dispatch_ready,
    output logic [2:0]                   dispatch_unit,
    output logic [`UNIT_SIZE-1:0]        dispatch_tag,
    output logic signed [`WORD_SIZE-1:0] dispatch_a,
    output logic signed [`WORD_SIZE-1:0] dispatch_b,
    output logic signed [`WORD_SIZE-1:0] dispatch_c,
    input  logic                         cdb_valid,
    input  logic [`UNIT_SIZE-1:0]        cdb_tag,
    input  logic signed [`WORD_SIZE-1:0] cdb_value
);
    localparam int RW    = `REG_SIZE;
    localparam int WW    = `WORD_SIZE;
    localparam int TW    = `UNIT_SIZE;
    localparam int NREGS = 1 << RW;
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    localparam logic [2:0] U_LW   = 3'd0;
    localparam logic [2:0] U_SW   = 3'd1;
    localparam logic [2:0] U_ADD  = 3'd2;
    localparam logic [2:0] U_MUL  = 3'd3;
    localparam logic [2:0] U_MV   = 3'd4;
    localparam logic [2:0] U_HALT = 3'd5;

    logic signed [WW-1:0] rf_val_q [NREGS];
    logic [TW-1:0]        rf_tag_q [NREGS];

    // Operand slots per entry: 0 = A, 1 = B, 2 = C (store data).
    logic [ENTRIES-1:0]   ent_vld_q;
    logic [ENTRIES-1:0]   ent_disp_q;
    logic [2:0]           ent_unit_q [ENTRIES];
    logic signed [WW-1:0] op_val_q   [ENTRIES][3];
    logic [TW-1:0]        op_tag_q   [ENTRIES][3];
    logic [2:0]           op_rdy_q   [ENTRIES];

    logic                 halted_q;
    logic                 disp_vld_q;
    logic [IDX_W-1:0]     disp_idx_q;
    logic [2:0]           disp_unit_q;
    logic signed [WW-1:0] disp_a_q, disp_b_q, disp_c_q;

    logic                 has_free, cdb_block, byp_en;
    logic                 accept, is_halt, do_alloc, do_rename, xfer, disp_load_d;
    logic [IDX_W-1:0]     alloc_idx;
    logic [RW-1:0]        src_reg [3];
    logic signed [WW-1:0] src_val [3];
    logic [TW-1:0]        src_tag [3];
    logic [2:0]           src_rdy;
    logic signed [WW-1:0] new_val [3];
    logic [TW-1:0]        new_tag [3];
    logic [2:0]           new_rdy;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;

    always_comb begin
        has_free  = 1'b0;
        alloc_idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (!ent_vld_q[e]) begin
                has_free  = 1'b1;
                alloc_idx = IDX_W'(e);
            end
        end
    end

`ifdef ISSUE_BYPASS_EN
    assign cdb_block = 1'b0;
    assign byp_en    = cdb_valid;
`else
    assign cdb_block = cdb_valid;
    assign byp_en    = 1'b0;
`endif

    assign out       = halted_q | ~has_free | cdb_block;
    assign accept    = enable & ~out;
    assign is_halt   = (unit == U_HALT);
    assign do_alloc  = accept & ~is_halt;
    assign do_rename = do_alloc & ((unit == U_LW) | (unit == U_ADD) | (unit == U_MUL) | (unit == U_MV));
    assign xfer      = disp_vld_q & dispatch_ready;

    // Sources read the pre-rename register state; a same-cycle rename of reg1 only affects later issues.
    always_comb begin
        src_reg[0] = reg2;
        src_reg[1] = reg3;
        src_reg[2] = reg1;
        for (int k = 0; k < 3; k++) begin
            src_val[k] = rf_val_q[src_reg[k]];
            src_tag[k] = rf_tag_q[src_reg[k]];
            src_rdy[k] = (src_tag[k] == READY_TAG);
            if (!src_rdy[k] && byp_en && (src_tag[k] == cdb_tag)) begin
                src_val[k] = cdb_value;
                src_rdy[k] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            new_val[k] = '0;
            new_tag[k] = READY_TAG;
            new_rdy[k] = 1'b1;
        end
        if (unit == U_MV && hasimm) begin
            new_val[0] = imm;
        end else begin
            new_val[0] = src_val[0];
            new_tag[0] = src_tag[0];
            new_rdy[0] = src_rdy[0];
        end
        if (unit != U_MV) begin
            if (hasimm) begin
                new_val[1] = imm;
            end else begin
                new_val[1] = src_val[1];
                new_tag[1] = src_tag[1];
                new_rdy[1] = src_rdy[1];
            end
        end
        if (unit == U_SW) begin
            new_val[2] = src_val[2];
            new_tag[2] = src_tag[2];
            new_rdy[2] = src_rdy[2];
        end
    end

    // Candidates exclude the entry leaving this cycle and any entry the CDB is freeing.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (ent_vld_q[e] && !ent_disp_q[e] && (&op_rdy_q[e]) &&
                !(xfer && (disp_idx_q == IDX_W'(e))) &&
                !(cdb_valid && (cdb_tag == TW'(e)))) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(e);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld_q  <= '0;
            ent_disp_q <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                ent_unit_q[e] <= '0;
                op_rdy_q[e]   <= '0;
                for (int k = 0; k < 3; k++) begin
                    op_val_q[e][k] <= '0;
                    op_tag_q[e][k] <= READY_TAG;
                end
            end
        end else begin
            for (int e = 0; e < ENTRIES; e++) begin
                for (int k = 0; k < 3; k++) begin
                    if (cdb_valid && ent_vld_q[e] && !op_rdy_q[e][k] && (op_tag_q[e][k] == cdb_tag)) begin
                        op_val_q[e][k] <= cdb_value;
                        op_rdy_q[e][k] <= 1'b1;
                    end
                end
                if (xfer && (disp_idx_q == IDX_W'(e))) begin
                    ent_disp_q[e] <= 1'b1;
                end
                if (cdb_valid && (cdb_tag == TW'(e))) begin
                    ent_vld_q[e] <= 1'b0;
                end
                if (do_alloc && (alloc_idx == IDX_W'(e))) begin
                    ent_vld_q[e]  <= 1'b1;
                    ent_disp_q[e] <= 1'b0;
                    ent_unit_q[e] <= unit;
                    op_rdy_q[e]   <= new_rdy;
                    for (int k = 0; k < 3; k++) begin
                        op_val_q[e][k] <= new_val[k];
                        op_tag_q[e][k] <= new_tag[k];
                    end
                end
            end
        end
    end

    // Rename is applied after the CDB update so it wins on the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                rf_val_q[r] <= '0;
                rf_tag_q[r] <= READY_TAG;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (cdb_valid && (rf_tag_q[r] == cdb_tag)) begin
                    rf_val_q[r] <= cdb_value;
                    rf_tag_q[r] <= READY_TAG;
                end
                if (do_rename && (reg1 == RW'(r))) begin
                    rf_tag_q[r] <= TW'(alloc_idx);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (accept && is_halt) begin
            halted_q <= 1'b1;
        end
    end

    assign disp_load_d = ~disp_vld_q | dispatch_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_vld_q  <= 1'b0;
            disp_idx_q  <= '0;
            disp_unit_q <= '0;
            disp_a_q    <= '0;
            disp_b_q    <= '0;
            disp_c_q    <= '0;
        end else if (disp_load_d) begin
            disp_vld_q  <= pick_vld;
            disp_idx_q  <= pick_idx;
            disp_unit_q <= ent_unit_q[pick_idx];
            disp_a_q    <= op_val_q[pick_idx][0];
            disp_b_q    <= op_val_q[pick_idx][1];
            disp_c_q    <= op_val_q[pick_idx][2];
        end
    end

    assign dispatch_valid = disp_vld_q;
    assign dispatch_unit  = disp_unit_q;
    assign dispatch_tag   = TW'(disp_idx_q);
    assign dispatch_a     = disp_a_q;
    assign dispatch_b     = disp_b_q;
    assign dispatch_c     = disp_c_q;

    assign regout   = regread ? rf_tag_q[regin] : '0;
    assign regoutrf = regread ? rf_val_q[regin] : '0;

endmodule
